// File: rtl/photon_cps_limiter.sv
// photon_cps_limiter
// ------------------
// Polices the photon event stream and passes at most cps_lim events in each
// one-second window (TICKS_PER_SEC user_clk cycles). Events beyond the limit
// are dropped. The block reports window boundaries and per-window statistics
// to the capture logic.
//
// Optional build macro: CPS_LIM_STATS_EN
//   defined   : a saturating drop counter is built and last_drop reports the
//               previous window's dropped-event count.
//   undefined : no drop counter is built and last_drop is tied to 0.
//
// Ports
//   user_clk    in   1       sole clock (capture/user domain)
//   user_rst    in   1       synchronous, active-high reset
//   cps_lim     in   32      events allowed per window, 0 = unlimited
//   in_valid    in   1       photon event valid
//   in_data     in   DATA_W  photon event word
//   out_valid   out  1       accepted event valid (1-cycle latency)
//   out_data    out  DATA_W  accepted event word (holds when out_valid = 0)
//   sec_pulse   out  1       high on the last cycle of each window
//   limited     out  1       high while the current window is at its limit
//   win_count   out  32      accepted events in the current window
//   last_accept out  32      accepted count of the previous window
//   last_drop   out  32      dropped count of the previous window
module photon_cps_limiter #(
  parameter int DATA_W        = 64,
  parameter int TICKS_PER_SEC = 250000000,
  parameter int TICK_W        = 28
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       cps_lim,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sec_pulse,
  output logic              limited,
  output logic [31:0]       win_count,
  output logic [31:0]       last_accept,
  output logic [31:0]       last_drop
);

  // Last tick of a window, and the tick before it (sec_pulse is registered,
  // so it is set one cycle early to line up with the last tick).
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICKS_PER_SEC - 2);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  typedef enum logic [0:0] {
    ST_PASS    = 1'b0,
    ST_LIMITED = 1'b1
  } state_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    logic [31:0] result;
    if (en && (value != 32'hFFFF_FFFF)) begin
      result = value + 32'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [TICK_W-1:0]   tick_r;
  logic                win_end_s;
  logic [31:0]         lim_q_r;
  logic [31:0]         win_count_r;
  logic [31:0]         win_count_inc_s;
  logic [31:0]         last_accept_r;
  logic                accept_s;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                sec_pulse_r;
  logic                limited_r;

  assign win_end_s       = (tick_r == TICK_LAST);
  assign win_count_inc_s = sat_inc(win_count_r, accept_s);

  // State register.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_r <= ST_PASS;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: every window opens in PASS; the accept that reaches
  // a non-zero limit moves the window into LIMITED.
  always_comb begin
    state_next_s = state_r;
    if (win_end_s) begin
      state_next_s = ST_PASS;
    end else begin
      case (state_r)
        ST_PASS: begin
          if (accept_s && (lim_q_r != 32'd0) && (win_count_inc_s == lim_q_r)) begin
            state_next_s = ST_LIMITED;
          end else begin
            state_next_s = ST_PASS;
          end
        end
        ST_LIMITED: state_next_s = ST_LIMITED;
        default:    state_next_s = ST_PASS;
      endcase
    end
  end

  // Output decode: accept decision for the event presented this cycle.
  // The count compare is kept alongside the state so an accept can never
  // push the window past its limit.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_PASS: begin
        if (in_valid && ((lim_q_r == 32'd0) || (win_count_r < lim_q_r))) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_LIMITED: accept_s = 1'b0;
      default:    accept_s = 1'b0;
    endcase
  end

  // Window timer, limit sampling, accept path and per-window counters.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      tick_r        <= '0;
      sec_pulse_r   <= 1'b0;
      lim_q_r       <= cps_lim;
      win_count_r   <= 32'd0;
      last_accept_r <= 32'd0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      limited_r     <= 1'b0;
    end else begin
      tick_r      <= win_end_s ? '0 : (tick_r + TICK_ONE);
      sec_pulse_r <= (tick_r == TICK_PRE);
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_data_r <= in_data;
      end
      limited_r <= (state_next_s == ST_LIMITED);
      if (win_end_s) begin
        // The terminal-cycle event is already folded into win_count_inc_s.
        last_accept_r <= win_count_inc_s;
        win_count_r   <= 32'd0;
        lim_q_r       <= cps_lim;
      end else begin
        win_count_r   <= win_count_inc_s;
      end
    end
  end

`ifdef CPS_LIM_STATS_EN
  logic        drop_s;
  logic [31:0] drop_cnt_r;
  logic [31:0] drop_cnt_inc_s;
  logic [31:0] last_drop_r;

  assign drop_s         = in_valid && !accept_s;
  assign drop_cnt_inc_s = sat_inc(drop_cnt_r, drop_s);

  // Dropped-event counter, captured and cleared at each window end.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      drop_cnt_r  <= 32'd0;
      last_drop_r <= 32'd0;
    end else if (win_end_s) begin
      last_drop_r <= drop_cnt_inc_s;
      drop_cnt_r  <= 32'd0;
    end else begin
      drop_cnt_r  <= drop_cnt_inc_s;
    end
  end

  assign last_drop = last_drop_r;
`else
  assign last_drop = 32'd0;
`endif

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign sec_pulse   = sec_pulse_r;
  assign limited     = limited_r;
  assign win_count   = win_count_r;
  assign last_accept = last_accept_r;

endmodule
